mem_wb_multi: RTL
=================

# mem_wb_multi

Parametrised MEM→WB pipeline register for the multi-issue core. It carries NUM_CH register-write channels from the memory stage to the register-file write ports. It applies stall/bubble semantics, flush, rdy freeze, x0 suppression and same-cycle write-conflict resolution. A wrapping counter tracks retired register writes for performance monitoring.

## Interface
Parameters:
- NUM_CH, 2, number of write channels (1..4)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- stall_cur  in  1  this stage stalled
- stall_next  in  1  WB stage stalled
- flush  in  1  discard contents, insert bubble
- mem_rd_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- mem_rd_addr  in  NUM_CH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- mem_rd_enable  in  NUM_CH  per-channel write enable
- wb_rd_data  out  NUM_CH*DATA_W  registered data
- wb_rd_addr  out  NUM_CH*ADDR_W  registered address
- wb_rd_enable  out  NUM_CH  registered, filtered enable
- retire_cnt  out  CNT_W  total committed writes, wraps modulo 2^CNT_W

## Operation
- Reset values: all wb_* outputs are 0 and retire_cnt is 0.
- Update actions are evaluated each rising edge in this priority order:
  1. rst: all outputs go to reset values.
  2. rdy=0: every register holds, including retire_cnt. flush and stall are ignored that cycle.
  3. flush=1: bubble. All wb_* are 0 and retire_cnt holds.
  4. stall_cur=1, stall_next=0: bubble, same as flush.
  5. stall_cur=1, stall_next=1: hold all wb_* and retire_cnt.
  6. stall_cur=0: load the filtered inputs.
- Load filtering, evaluated combinationally on the inputs:
  - Channel i has effective enable en_i = mem_rd_enable[i] AND (mem_rd_addr_i != 0). Writes to x0 are dropped.
  - Conflict rule: if en_i and en_j with i<j and addr_i == addr_j, en_i is cleared. The highest-index channel wins, because it is the youngest in program order.
  - Data and address of every channel are loaded as given, even if the channel's enable was cleared.
- On a load, retire_cnt += popcount(filtered enables). Addition is modulo 2^CNT_W; there is no saturation.
- Bubbles and holds never change retire_cnt.
- NUM_CH=1 degenerates to a single-channel register with x0 suppression; the conflict logic is absent.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on wb_* after edge N and stay stable through edge N+1.
- No combinational path from any input to any output.
- A bubble takes effect at the same edge it is sampled. The next non-stalled cycle loads normally, with no extra bubble.
- Hold (stall_cur=stall_next=1) can last indefinitely. On release with stall_cur=0, the new input loads at that edge.
- flush together with stall_cur=1, stall_next=1: flush wins and a bubble is inserted.
- rdy=0 together with rst=1: reset wins.
- retire_cnt updates at the same edge as the corresponding wb_rd_enable.

## Test plan
- Reset: assert rst for 2 cycles with nonzero inputs → all wb_* = 0 and retire_cnt = 0; first load after deassert appears 1 cycle later.
- Basic load and x0, NUM_CH=2: ch0 {en=1, addr=5, data=0xDEADBEEF}, ch1 {en=1, addr=0, data=0x1234} → wb_rd_enable=2'b01, wb data ch0=0xDEADBEEF, retire_cnt +1.
- Conflict: ch0 {en=1, addr=7, data=0x11}, ch1 {en=1, addr=7, data=0x22} → wb_rd_enable=2'b10, ch1 data 0x22, retire_cnt +1.
- Stall semantics:
  - Load addr 3, then stall_cur=1, stall_next=0 → wb_rd_enable=0 next cycle.
  - Load addr 3, then stall_cur=stall_next=1 for 3 cycles → wb outputs hold addr 3 and retire_cnt does not change.
- rdy freeze: hold rdy=0 for 4 cycles while toggling inputs, flush and stall → outputs and retire_cnt unchanged. rdy=1 with stall_cur=0 → loads the current input.
- Counter wrap (CNT_W=4): preload to 15 via 15 single-write loads, then one 2-write load → retire_cnt = 1.

Source files
------------

// File: rtl/mem_wb_multi.sv
// MEM->WB pipeline register for NUM_CH register-write channels.
// Handles bubble/hold/freeze control, x0 suppression, same-cycle conflicts and a retire counter.
module mem_wb_multi #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     stall_cur,
    input  logic                     stall_next,
    input  logic                     flush,
    input  logic [NUM_CH*DATA_W-1:0] mem_rd_data,
    input  logic [NUM_CH*ADDR_W-1:0] mem_rd_addr,
    input  logic [NUM_CH-1:0]        mem_rd_enable,
    output logic [NUM_CH*DATA_W-1:0] wb_rd_data,
    output logic [NUM_CH*ADDR_W-1:0] wb_rd_addr,
    output logic [NUM_CH-1:0]        wb_rd_enable,
    output logic [CNT_W-1:0]         retire_cnt
);

    logic [NUM_CH-1:0] eff_en;
    logic [NUM_CH-1:0] filt_en;
    logic [CNT_W-1:0]  load_cnt;
    logic              bubble;

    assign bubble = flush || (stall_cur && !stall_next);

    // The youngest (highest-index) channel wins when several write the same register.
    always_comb begin
        eff_en   = '0;
        filt_en  = '0;
        load_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eff_en[i] = mem_rd_enable[i] && (mem_rd_addr[i*ADDR_W +: ADDR_W] != '0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            filt_en[i] = eff_en[i];
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (eff_en[j] && (mem_rd_addr[j*ADDR_W +: ADDR_W] == mem_rd_addr[i*ADDR_W +: ADDR_W])) begin
                    filt_en[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            load_cnt = load_cnt + CNT_W'(filt_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_data   <= '0;
            wb_rd_addr   <= '0;
            wb_rd_enable <= '0;
            retire_cnt   <= '0;
        end else if (rdy) begin
            if (bubble) begin
                wb_rd_data   <= '0;
                wb_rd_addr   <= '0;
                wb_rd_enable <= '0;
            end else if (!stall_cur) begin
                wb_rd_data   <= mem_rd_data;
                wb_rd_addr   <= mem_rd_addr;
                wb_rd_enable <= filt_en;
                retire_cnt   <= retire_cnt + load_cnt;
            end
        end
    end

endmodule
